// File: rtl/mp64_mem_ctrl_pkg.sv
// Shared encodings, FSM states and lane helpers for the mp64 memory target.
package mp64_mem_ctrl_pkg;

  localparam logic [1:0] MP64_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] MP64_SIZE_HALF  = 2'd1;
  localparam logic [1:0] MP64_SIZE_WORD  = 2'd2;
  localparam logic [1:0] MP64_SIZE_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_EXT_WAIT = 2'd2,
    ST_COOL     = 2'd3
  } mp64_state_e;

  // Byte-lane enable for an access of the given size at lane offset 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      MP64_SIZE_BYTE: lane_mask = 8'h01;
      MP64_SIZE_HALF: lane_mask = 8'h03;
      MP64_SIZE_WORD: lane_mask = 8'h0F;
      default:        lane_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      MP64_SIZE_BYTE: size_mask = 64'h0000_0000_0000_00FF;
      MP64_SIZE_HALF: size_mask = 64'h0000_0000_0000_FFFF;
      MP64_SIZE_WORD: size_mask = 64'h0000_0000_FFFF_FFFF;
      default:        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      MP64_SIZE_BYTE: align_mask = 3'b000;
      MP64_SIZE_HALF: align_mask = 3'b001;
      MP64_SIZE_WORD: align_mask = 3'b011;
      default:        align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mp64_mem_ctrl_bram.sv
// Single-port synchronous-read RAM, 64-bit words with per-byte write enables.
module mp64_bram #(
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [7:0]           we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [63:0]          wdata,
  output logic [63:0]          rdata
);

  logic [63:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mp64_mem_ctrl.sv
// Bus memory target: low addresses hit internal BRAM, the rest go to the
// external port under a timeout watchdog.
//   state       | meaning
//   ST_IDLE     | waiting for mem_req, decode region/alignment
//   ST_RD_WAIT  | BRAM read data valid, steer and ack
//   ST_EXT_WAIT | external request outstanding, watchdog counting
//   ST_COOL     | ack cycle, mem_req ignored while the bus drops it
module mp64_mem_ctrl
  import mp64_mem_ctrl_pkg::*;
#(
  parameter int BRAM_ADDR_BITS = 16,
  parameter int EXT_TIMEOUT    = 1024,
  parameter int TO_BITS        = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  output logic [63:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        ext_req,
  output logic [63:0] ext_addr,
  output logic [63:0] ext_wdata,
  output logic        ext_wen,
  output logic [1:0]  ext_size,
  input  logic [63:0] ext_rdata,
  input  logic        ext_ack
);

  localparam int WORD_BITS = BRAM_ADDR_BITS - 3;

  mp64_state_e state_q, state_d;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic        ext_req_q, ext_req_d, ext_wen_q, ext_wen_d;
  logic [63:0] ext_addr_q, ext_addr_d, ext_wdata_q, ext_wdata_d;
  logic [1:0]  ext_size_q, ext_size_d;
  logic [2:0]  rd_off_q, rd_off_d;
  logic [1:0]  rd_size_q, rd_size_d;

  logic        is_int, misal, bram_en;
  logic [2:0]  off;
  logic [7:0]  be, bram_we;
  logic [63:0] wdata_sh, bram_rdata;

  assign off      = mem_addr[2:0];
  assign is_int   = (mem_addr[63:BRAM_ADDR_BITS] == '0);
  assign misal    = |(off & align_mask(mem_size));
  assign be       = lane_mask(mem_size) << off;
  assign wdata_sh = mem_wdata << {off, 3'b000};

  mp64_bram #(.ADDR_BITS(WORD_BITS)) u_bram (
    .clk   (clk),
    .en    (bram_en),
    .we    (bram_we),
    .addr  (mem_addr[BRAM_ADDR_BITS-1:3]),
    .wdata (wdata_sh),
    .rdata (bram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    ext_req_d   = ext_req_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_wen_d   = ext_wen_q;
    ext_size_d  = ext_size_q;
    rd_off_d    = rd_off_q;
    rd_size_d   = rd_size_q;
    bram_en     = 1'b0;
    bram_we     = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          if (!is_int) begin
            ext_req_d   = 1'b1;
            ext_addr_d  = mem_addr;
            ext_wdata_d = mem_wdata;
            ext_wen_d   = mem_wen;
            ext_size_d  = mem_size;
            to_cnt_d    = '0;
            state_d     = ST_EXT_WAIT;
          end else if (misal) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_COOL;
          end else if (mem_wen) begin
            bram_en = 1'b1;
            bram_we = be;
            ack_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_COOL;
          end else begin
            bram_en   = 1'b1;
            rd_off_d  = off;
            rd_size_d = mem_size;
            state_d   = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        rdata_d = (bram_rdata >> {rd_off_q, 3'b000}) & size_mask(rd_size_q);
        ack_d   = 1'b1;
        state_d = ST_COOL;
      end
      ST_EXT_WAIT: begin
        // ext_ack is checked first so it wins over a coincident timeout
        if (ext_ack) begin
          ext_req_d = 1'b0;
          ack_d     = 1'b1;
          rdata_d   = ext_wen_q ? 64'd0 : ext_rdata;
          state_d   = ST_COOL;
        end else if (to_cnt_q == TO_BITS'(EXT_TIMEOUT - 1)) begin
          ext_req_d = 1'b0;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '1;
          state_d   = ST_COOL;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_COOL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_wen_q   <= 1'b0;
      ext_size_q  <= '0;
      rd_off_q    <= '0;
      rd_size_q   <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      ext_req_q   <= ext_req_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_wen_q   <= ext_wen_d;
      ext_size_q  <= ext_size_d;
      rd_off_q    <= rd_off_d;
      rd_size_q   <= rd_size_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ack   = ack_q;
  assign mem_err   = err_q;
  assign ext_req   = ext_req_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ext_wen   = ext_wen_q;
  assign ext_size  = ext_size_q;

endmodule

// File: doc/mp64_mem_ctrl.md
Name: mp64_mem_ctrl

Overview:
Memory subsystem target that sits directly downstream of the multi-master bus arbiter and consumes its mem_req/mem_ack channel. It serves low addresses from internal byte-enabled BRAM and forwards all other addresses to an external memory port with a timeout watchdog. It handles byte, half, word and dword sizes, with lane steering and misalignment detection.

Parameters:
BRAM_ADDR_BITS, 16, byte-address width of internal BRAM (64 KiB = 8192 x 64-bit words)
EXT_TIMEOUT, 1024, cycles of waiting for ext_ack before the access is aborted with an error
TO_BITS, 11, timeout counter width; must hold EXT_TIMEOUT

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
mem_req  in  1  request from bus; level, held until mem_ack
mem_addr  in  64  byte address
mem_wdata  in  64  write data, right-justified
mem_wen  in  1  1 = write
mem_size  in  2  0 = byte, 1 = half, 2 = word32, 3 = dword
mem_rdata  out  64  read data, right-justified, zero-extended
mem_ack  out  1  one-cycle completion pulse
mem_err  out  1  valid with mem_ack; misaligned access or external timeout
ext_req  out  1  external request, held until ext_ack or timeout
ext_addr  out  64  external address
ext_wdata  out  64  external write data, passed unmodified
ext_wen  out  1  external write enable
ext_size  out  2  external size
ext_rdata  in  64  external read data
ext_ack  in  1  external completion, one cycle

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All flops clear on reset: all outputs 0, state IDLE, timeout counter 0. BRAM contents are not reset.
- Region decode: internal if mem_addr[63:BRAM_ADDR_BITS] == 0, else external.
- Misalignment: access is misaligned if addr[2:0] is not a multiple of (1 << size). Internal misaligned access: no BRAM write; ack at T+1 with mem_err = 1 and mem_rdata = 0. External accesses are not alignment-checked.
- Lanes: off = addr[2:0]. Byte enable = ((1 << (1 << size)) - 1) << off. Write data = wdata << (off*8). Read data = (word >> (off*8)) masked to the size.
- States: IDLE, RD_WAIT, EXT_WAIT, COOL.
- IDLE: mem_req sampled at cycle T.
  - Internal write: BRAM write at T. Next state COOL with mem_ack = 1 at T+1.
  - Internal read: BRAM read issued at T; go to RD_WAIT.
  - External: ext_* registered, ext_req = 1 at T+1; go to EXT_WAIT.
- RD_WAIT: BRAM data is valid. Steer it, then register mem_rdata and mem_ack (visible at T+2). Go to COOL.
- EXT_WAIT: counter increments each cycle.
  - On ext_ack: ext_req = 0; mem_rdata = ext_rdata (reads only; writes leave mem_rdata at 0); mem_ack pulses the next cycle; go to COOL.
  - If the counter reaches EXT_TIMEOUT - 1 without ext_ack: ext_req = 0; mem_ack = 1 with mem_err = 1 and mem_rdata = all ones; go to COOL.
  - ext_ack arriving in the same cycle as the timeout: ext_ack wins and mem_err = 0.
- COOL: one cycle, mem_req ignored, because the bus deasserts mem_req the cycle after ack. Then IDLE.
- mem_ack and mem_err are cleared every cycle except the pulse cycle. mem_rdata holds its value until the next ack.
- Latency: internal write 1 cycle, internal read 2 cycles, external ext_ack cycle + 1.
- Reset mid-operation: ext_req drops immediately (async clear). An in-flight BRAM write issued in the reset cycle need not complete.
- ext_ack received while not in EXT_WAIT is ignored.

Decomposition:
- Shared package: MP64_SIZE_BYTE/HALF/WORD/DWORD encodings, the memory FSM state localparams, and a lane-mask function.
- One sub-module: mp64_bram, a single-port synchronous-read RAM with 8 byte-enables, depth 2^(BRAM_ADDR_BITS-3) x 64.
- Steering and decode stay in mp64_mem_ctrl.

Test Plan:
- Dword write 0x1122334455667788 to 0x100, then dword read of 0x100 -> write ack at T+1 with err = 0; read ack at T+2 with rdata = 0x1122334455667788.
- Byte write 0xAB to 0x103, then dword read of 0x100 -> rdata = 0x11223344AB667788. Half read of 0x102 -> 0x0000000000AB66.
- Word read of 0x102 (misaligned) -> ack at T+1, err = 1, rdata = 0. Following dword read of 0x100 still returns 0x11223344AB667788.
- External read of 0x8000_0000 with ext_ack after 5 cycles carrying 0xDEADBEEF -> ext_addr = 0x80000000, ext_req held 5 cycles, mem_ack the next cycle with rdata = 0xDEADBEEF, err = 0.
- External write with no ext_ack -> ext_req drops after EXT_TIMEOUT cycles; mem_ack with err = 1 and rdata = 0xFFFFFFFFFFFFFFFF. A late ext_ack in IDLE produces no ack.
- Assert rst_n low during EXT_WAIT -> ext_req and mem_ack go 0 without waiting for clk. After release, a new internal read completes normally at T+2.
